// File: rtl/text_console_writer_if.sv
// ---------------------------------------------------------------------------
// text_console_writer_if
//   Byte-stream handshake into the text console writer.
//
//   char_in     8  byte to display, or a control code
//   fg_in       3  foreground colour that goes with char_in
//   bg_in       3  background colour that goes with char_in
//   char_valid  1  char_in / fg_in / bg_in are valid
//   char_ready  1  the writer accepts a byte on this cycle's posedge
//
//   master : byte source (drives data and valid, observes ready)
//   slave  : console writer (observes data and valid, drives ready)
// ---------------------------------------------------------------------------
interface text_console_writer_if;
  logic [7:0] char_in;
  logic [2:0] fg_in;
  logic [2:0] bg_in;
  logic       char_valid;
  logic       char_ready;

  modport master (
    output char_in,
    output fg_in,
    output bg_in,
    output char_valid,
    input  char_ready
  );

  modport slave (
    input  char_in,
    input  fg_in,
    input  bg_in,
    input  char_valid,
    output char_ready
  );
endinterface

// File: rtl/text_console_writer.sv
// ---------------------------------------------------------------------------
// text_console_writer
//   Writer side of the 80x60 text-mode video path. Takes bytes from a
//   valid/ready stream, interprets control codes, keeps the cursor and
//   writes character + colour cells into the character RAM that the VGA
//   text renderer reads. Scrolling is done by advancing a circular row
//   offset (scroll_row) and blanking the row that wraps around to the
//   bottom, so no read-back or copy of the RAM is ever needed.
//
//   Ports
//     clk         system clock, all logic on posedge
//     reset       synchronous reset, active-high
//     stream      byte stream (slave side): char_in, fg_in, bg_in,
//                 char_valid in, char_ready out
//     wr_en       character RAM write strobe, one cycle per cell
//     wr_addr     {col[6:0], physical_row[5:0]}
//     wr_char     character code to write
//     wr_fg       foreground colour to write
//     wr_bg       background colour to write
//     cursor_col  logical cursor column
//     cursor_row  logical cursor row (0 = top visible line)
//     scroll_row  physical RAM row displayed as the top line
//     busy        clear-line or clear-screen sequence in progress
//
//   Control codes
//     0x20..0x7F  printable: write at cursor, advance column (wraps with
//                 a line advance at the last column)
//     0x0D CR     column to 0
//     0x0A LF     line advance, column unchanged
//     0x08 BS     step back one column and blank that cell (no-op at col 0)
//     0x0C FF     home cursor, reset scroll, clear the whole screen
//     others      consumed and ignored
// ---------------------------------------------------------------------------
module text_console_writer #(
  parameter int COLS           = 80,
  parameter int ROWS           = 60,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  text_console_writer_if.slave       stream,
  output logic                       wr_en,
  output logic [12:0]                wr_addr,
  output logic [7:0]                 wr_char,
  output logic [2:0]                 wr_fg,
  output logic [2:0]                 wr_bg,
  output logic [6:0]                 cursor_col,
  output logic [5:0]                 cursor_row,
  output logic [5:0]                 scroll_row,
  output logic                       busy
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
  localparam logic [6:0] ROWS_W   = 7'(ROWS);

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLR_LINE   = 2'd1,
    CLR_SCREEN = 2'd2
  } state_t;

  state_t      state_reg;
  logic [6:0]  col_reg;
  logic [5:0]  row_reg;
  logic [5:0]  scroll_reg;
  logic [2:0]  attr_fg_reg;
  logic [2:0]  attr_bg_reg;
  // Position of the next blanking write during CLR_LINE / CLR_SCREEN.
  // clr_row_reg is a physical row.
  logic [6:0]  clr_col_reg;
  logic [5:0]  clr_row_reg;

  logic        wr_en_reg;
  logic [12:0] wr_addr_reg;
  logic [7:0]  wr_char_reg;
  logic [2:0]  wr_fg_reg;
  logic [2:0]  wr_bg_reg;

  // Physical row of the cursor, wrapping at ROWS (not at 64).
  logic [6:0]  phys_sum;
  logic [5:0]  phys_row;
  logic [5:0]  scroll_next;
  logic        printable;
  logic        accept;

  always_comb begin
    phys_sum = {1'b0, scroll_reg} + {1'b0, row_reg};
    phys_row = phys_sum[5:0];
    if (phys_sum >= ROWS_W) begin
      phys_row = 6'(phys_sum - ROWS_W);
    end
  end

  assign scroll_next = (scroll_reg == LAST_ROW) ? 6'd0 : scroll_reg + 6'd1;

  // 0x20..0x7F: bit 7 clear and bits 6:5 not both zero.
  assign printable = !stream.char_in[7] && (stream.char_in[6:5] != 2'b00);

  assign stream.char_ready = (state_reg == IDLE) && !reset;
  assign accept            = stream.char_valid && stream.char_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= CLEAR_ON_RESET ? CLR_SCREEN : IDLE;
      col_reg     <= 7'd0;
      row_reg     <= 6'd0;
      scroll_reg  <= 6'd0;
      attr_fg_reg <= 3'b111;
      attr_bg_reg <= 3'b000;
      clr_col_reg <= 7'd0;
      clr_row_reg <= 6'd0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= 13'd0;
      wr_char_reg <= CH_SPACE;
      wr_fg_reg   <= 3'b111;
      wr_bg_reg   <= 3'b000;
    end else begin
      wr_en_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            attr_fg_reg <= stream.fg_in;
            attr_bg_reg <= stream.bg_in;
            if (printable) begin
              wr_en_reg   <= 1'b1;
              wr_addr_reg <= {col_reg, phys_row};
              wr_char_reg <= stream.char_in;
              wr_fg_reg   <= stream.fg_in;
              wr_bg_reg   <= stream.bg_in;
              if (col_reg == LAST_COL) begin
                col_reg <= 7'd0;
                // Line advance after wrapping off the last column.
                if (row_reg != LAST_ROW) begin
                  row_reg <= row_reg + 6'd1;
                end else begin
                  // The row at the top of the screen becomes the new
                  // bottom line once scroll_row moves past it.
                  clr_col_reg <= 7'd0;
                  clr_row_reg <= scroll_reg;
                  state_reg   <= CLR_LINE;
                end
              end else begin
                col_reg <= col_reg + 7'd1;
              end
            end else begin
              unique case (stream.char_in)
                CH_CR: begin
                  col_reg <= 7'd0;
                end
                CH_LF: begin
                  if (row_reg != LAST_ROW) begin
                    row_reg <= row_reg + 6'd1;
                  end else begin
                    clr_col_reg <= 7'd0;
                    clr_row_reg <= scroll_reg;
                    state_reg   <= CLR_LINE;
                  end
                end
                CH_BS: begin
                  if (col_reg != 7'd0) begin
                    col_reg     <= col_reg - 7'd1;
                    wr_en_reg   <= 1'b1;
                    wr_addr_reg <= {col_reg - 7'd1, phys_row};
                    wr_char_reg <= CH_SPACE;
                    wr_fg_reg   <= stream.fg_in;
                    wr_bg_reg   <= stream.bg_in;
                  end
                end
                CH_FF: begin
                  col_reg     <= 7'd0;
                  row_reg     <= 6'd0;
                  scroll_reg  <= 6'd0;
                  clr_col_reg <= 7'd0;
                  clr_row_reg <= 6'd0;
                  state_reg   <= CLR_SCREEN;
                end
                default: begin
                end
              endcase
            end
          end
        end

        CLR_LINE: begin
          wr_en_reg   <= 1'b1;
          wr_addr_reg <= {clr_col_reg, clr_row_reg};
          wr_char_reg <= CH_SPACE;
          wr_fg_reg   <= attr_fg_reg;
          wr_bg_reg   <= attr_bg_reg;
          if (clr_col_reg == LAST_COL) begin
            clr_col_reg <= 7'd0;
            scroll_reg  <= scroll_next;
            state_reg   <= IDLE;
          end else begin
            clr_col_reg <= clr_col_reg + 7'd1;
          end
        end

        CLR_SCREEN: begin
          wr_en_reg   <= 1'b1;
          wr_addr_reg <= {clr_col_reg, clr_row_reg};
          wr_char_reg <= CH_SPACE;
          wr_fg_reg   <= attr_fg_reg;
          wr_bg_reg   <= attr_bg_reg;
          if (clr_col_reg == LAST_COL) begin
            clr_col_reg <= 7'd0;
            if (clr_row_reg == LAST_ROW) begin
              clr_row_reg <= 6'd0;
              state_reg   <= IDLE;
            end else begin
              clr_row_reg <= clr_row_reg + 6'd1;
            end
          end else begin
            clr_col_reg <= clr_col_reg + 7'd1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // The strobe is masked by reset so that a reset raised in the middle of
  // a sequence stops writes in the same cycle it is asserted.
  assign wr_en      = wr_en_reg && !reset;
  assign wr_addr    = wr_addr_reg;
  assign wr_char    = wr_char_reg;
  assign wr_fg      = wr_fg_reg;
  assign wr_bg      = wr_bg_reg;
  assign cursor_col = col_reg;
  assign cursor_row = row_reg;
  assign scroll_row = scroll_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_text_console_writer.sv
// ---------------------------------------------------------------------------
// tb_text_console_writer
//   Directed bench for text_console_writer: a table of single-byte vectors
//   with hand-computed results, plus sequences for clear-screen, line wrap,
//   scrolling, backspace and reset during a clear.
// ---------------------------------------------------------------------------
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [7:0]  wr_char;
  logic [2:0]  wr_fg;
  logic [2:0]  wr_bg;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic [5:0]  scroll_row;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  text_console_writer_if bus ();

  text_console_writer #(
    .COLS(80),
    .ROWS(60),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stream(bus),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_char(wr_char),
    .wr_fg(wr_fg),
    .wr_bg(wr_bg),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .scroll_row(scroll_row),
    .busy(busy)
  );

  typedef struct {
    logic [7:0]  c;
    logic [2:0]  fg;
    logic [2:0]  bg;
    logic        wr;
    logic [12:0] addr;
    logic [7:0]  ch;
    logic [6:0]  col;
    logic [5:0]  row;
  } tvec_t;

  tvec_t vec [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] addr_of(input int col, input int row);
    return 13'(col * 64 + row);
  endfunction

  // Waits (bounded) for char_ready, presents one byte for one accepting edge,
  // and returns one step after that edge, where the resulting write shows.
  task automatic send(input logic [7:0] c, input logic [2:0] fg, input logic [2:0] bg);
    int guard = 0;
    while (!bus.char_ready && guard < 10000) begin
      tick();
      guard++;
    end
    check("send_ready", {31'd0, bus.char_ready}, 32'd1);
    bus.char_in    = c;
    bus.fg_in      = fg;
    bus.bg_in      = bg;
    bus.char_valid = 1'b1;
    tick();
    bus.char_valid = 1'b0;
    $display("[TB] tx char=0x%02h fg=%0d bg=%0d -> wr_en=%0d addr=0x%04h col=%0d row=%0d scroll=%0d",
             c, fg, bg, wr_en, wr_addr, cursor_col, cursor_row, scroll_row);
  endtask

  // Follows one complete clear-screen sequence and checks every cell.
  task automatic check_clear_screen(input string name, input logic [2:0] fg, input logic [2:0] bg);
    int cnt = 0;
    int bad = 0;
    int guard = 0;
    logic [12:0] first_addr = 13'h1FFF;
    logic [12:0] last_addr = 13'h1FFF;
    while (!wr_en && guard < 100) begin
      tick();
      guard++;
    end
    check({name, "_start"}, {31'd0, wr_en}, 32'd1);
    check({name, "_ready_low"}, {31'd0, bus.char_ready}, 32'd0);
    while (wr_en && guard < 10000) begin
      if (wr_addr !== addr_of(cnt % 80, cnt / 80) || wr_char !== 8'h20 ||
          wr_fg !== fg || wr_bg !== bg) begin
        bad++;
      end
      if (cnt == 0) first_addr = wr_addr;
      last_addr = wr_addr;
      cnt++;
      tick();
      guard++;
    end
    $display("[TB] clear %s: %0d writes, %0d bad cells", name, cnt, bad);
    check({name, "_count"}, cnt, 32'd4800);
    check({name, "_bad_cells"}, bad, 32'd0);
    check({name, "_first_addr"}, {19'd0, first_addr}, 32'd0);
    check({name, "_last_addr"}, {19'd0, last_addr}, {19'd0, addr_of(79, 59)});
    check({name, "_ready_after"}, {31'd0, bus.char_ready}, 32'd1);
    check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cnt;
    int bad;
    int busy_cnt;

    bus.char_in    = 8'h00;
    bus.fg_in      = 3'd0;
    bus.bg_in      = 3'd0;
    bus.char_valid = 1'b0;
    reset          = 1'b1;

    // -------- reset state and boot-time clear --------
    tick();
    tick();
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_ready", {31'd0, bus.char_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_col", {25'd0, cursor_col}, 32'd0);
    check("rst_row", {26'd0, cursor_row}, 32'd0);
    check("rst_scroll", {26'd0, scroll_row}, 32'd0);
    reset = 1'b0;
    check_clear_screen("boot", 3'd7, 3'd0);

    // -------- table-driven single-byte vectors from (0,0) --------
    vec[0]  = '{8'h41, 3'd2, 3'd1, 1'b1, 13'd0,   8'h41, 7'd1, 6'd0};
    vec[1]  = '{8'h0D, 3'd0, 3'd0, 1'b0, 13'd0,   8'h00, 7'd0, 6'd0};
    vec[2]  = '{8'h0A, 3'd0, 3'd0, 1'b0, 13'd0,   8'h00, 7'd0, 6'd1};
    vec[3]  = '{8'h78, 3'd3, 3'd4, 1'b1, 13'd1,   8'h78, 7'd1, 6'd1};
    vec[4]  = '{8'h08, 3'd5, 3'd2, 1'b1, 13'd1,   8'h20, 7'd0, 6'd1};
    vec[5]  = '{8'h08, 3'd1, 3'd1, 1'b0, 13'd0,   8'h00, 7'd0, 6'd1};
    vec[6]  = '{8'h07, 3'd1, 3'd1, 1'b0, 13'd0,   8'h00, 7'd0, 6'd1};
    vec[7]  = '{8'h7F, 3'd6, 3'd7, 1'b1, 13'd1,   8'h7F, 7'd1, 6'd1};
    vec[8]  = '{8'h1B, 3'd0, 3'd0, 1'b0, 13'd0,   8'h00, 7'd1, 6'd1};
    vec[9]  = '{8'h0A, 3'd0, 3'd0, 1'b0, 13'd0,   8'h00, 7'd1, 6'd2};
    vec[10] = '{8'h80, 3'd0, 3'd0, 1'b0, 13'd0,   8'h00, 7'd1, 6'd2};
    vec[11] = '{8'h7E, 3'd0, 3'd7, 1'b1, 13'd66,  8'h7E, 7'd2, 6'd2};
    vec[12] = '{8'h20, 3'd7, 3'd0, 1'b1, 13'd130, 8'h20, 7'd3, 6'd2};
    vec[13] = '{8'h1F, 3'd4, 3'd4, 1'b0, 13'd0,   8'h00, 7'd3, 6'd2};

    for (int i = 0; i < 14; i++) begin
      send(vec[i].c, vec[i].fg, vec[i].bg);
      check($sformatf("vec%0d_wr_en", i), {31'd0, wr_en}, {31'd0, vec[i].wr});
      if (vec[i].wr) begin
        check($sformatf("vec%0d_addr", i), {19'd0, wr_addr}, {19'd0, vec[i].addr});
        check($sformatf("vec%0d_char", i), {24'd0, wr_char}, {24'd0, vec[i].ch});
        check($sformatf("vec%0d_fg", i), {29'd0, wr_fg}, {29'd0, vec[i].fg});
        check($sformatf("vec%0d_bg", i), {29'd0, wr_bg}, {29'd0, vec[i].bg});
      end
      check($sformatf("vec%0d_col", i), {25'd0, cursor_col}, {25'd0, vec[i].col});
      check($sformatf("vec%0d_row", i), {26'd0, cursor_row}, {26'd0, vec[i].row});
    end

    // -------- form feed clears with the FF byte's colours --------
    send(8'h0C, 3'd6, 3'd2);
    check("ff_col", {25'd0, cursor_col}, 32'd0);
    check("ff_row", {26'd0, cursor_row}, 32'd0);
    check_clear_screen("ff", 3'd6, 3'd2);

    // -------- line wrap at the last column --------
    for (int i = 0; i < 79; i++) begin
      send(8'h30 + 8'(i % 10), 3'd2, 3'd0);
    end
    check("wrap_col79", {25'd0, cursor_col}, 32'd79);
    send(8'h5A, 3'd1, 3'd0);
    check("wrap_z_wr", {31'd0, wr_en}, 32'd1);
    check("wrap_z_addr", {19'd0, wr_addr}, {19'd0, addr_of(79, 0)});
    check("wrap_z_char", {24'd0, wr_char}, 32'h5A);
    check("wrap_col", {25'd0, cursor_col}, 32'd0);
    check("wrap_row", {26'd0, cursor_row}, 32'd1);
    send(8'h0D, 3'd0, 3'd0);
    check("cr_no_wr", {31'd0, wr_en}, 32'd0);
    send(8'h0A, 3'd0, 3'd0);
    check("lf1_no_wr", {31'd0, wr_en}, 32'd0);
    send(8'h0A, 3'd0, 3'd0);
    check("lf2_no_wr", {31'd0, wr_en}, 32'd0);
    check("crlf_col", {25'd0, cursor_col}, 32'd0);
    check("crlf_row", {26'd0, cursor_row}, 32'd3);

    // -------- scroll: LF on the bottom line --------
    for (int i = 0; i < 56; i++) send(8'h0A, 3'd0, 3'd0);
    check("bottom_row", {26'd0, cursor_row}, 32'd59);
    for (int i = 0; i < 5; i++) send(8'h71, 3'd3, 3'd3);
    check("bottom_col", {25'd0, cursor_col}, 32'd5);
    check("pre_scroll", {26'd0, scroll_row}, 32'd0);
    send(8'h0A, 3'd5, 3'd1);
    check("scroll_lf_no_wr", {31'd0, wr_en}, 32'd0);
    check("scroll_busy", {31'd0, busy}, 32'd1);
    cnt = 0;
    bad = 0;
    busy_cnt = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (busy) busy_cnt++;
      if (wr_en) begin
        if (wr_addr !== addr_of(cnt, 0) || wr_char !== 8'h20 ||
            wr_fg !== 3'd5 || wr_bg !== 3'd1) bad++;
        cnt++;
      end
      if (!busy && !wr_en) break;
      tick();
    end
    $display("[TB] line clear: %0d writes, %0d busy cycles", cnt, busy_cnt);
    check("scroll_writes", cnt, 32'd80);
    check("scroll_bad_cells", bad, 32'd0);
    check("scroll_busy_cycles", busy_cnt, 32'd80);
    check("scroll_row_after", {26'd0, scroll_row}, 32'd1);
    check("scroll_col_after", {25'd0, cursor_col}, 32'd5);
    check("scroll_row_cursor", {26'd0, cursor_row}, 32'd59);
    send(8'h42, 3'd4, 3'd0);
    check("scroll_b_addr", {19'd0, wr_addr}, {19'd0, addr_of(5, 0)});
    check("scroll_b_wr", {31'd0, wr_en}, 32'd1);

    // -------- backspace at column 0 and column 3 --------
    send(8'h0C, 3'd7, 3'd0);
    check_clear_screen("ff2", 3'd7, 3'd0);
    for (int i = 0; i < 4; i++) send(8'h0A, 3'd0, 3'd0);
    send(8'h08, 3'd2, 3'd2);
    check("bs0_no_wr", {31'd0, wr_en}, 32'd0);
    check("bs0_col", {25'd0, cursor_col}, 32'd0);
    check("bs0_row", {26'd0, cursor_row}, 32'd4);
    send(8'h61, 3'd7, 3'd0);
    send(8'h62, 3'd7, 3'd0);
    send(8'h63, 3'd7, 3'd0);
    send(8'h08, 3'd4, 3'd3);
    check("bs3_wr", {31'd0, wr_en}, 32'd1);
    check("bs3_addr", {19'd0, wr_addr}, {19'd0, addr_of(2, 4)});
    check("bs3_char", {24'd0, wr_char}, 32'h20);
    check("bs3_fg", {29'd0, wr_fg}, 32'd4);
    check("bs3_bg", {29'd0, wr_bg}, 32'd3);
    check("bs3_col", {25'd0, cursor_col}, 32'd2);

    // -------- reset during the 2000th clear-screen write --------
    send(8'h0C, 3'd3, 3'd5);
    cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (wr_en) cnt++;
      if (cnt == 2000) break;
      tick();
    end
    check("mid_reached_2000", cnt, 32'd2000);
    reset = 1'b1;
    #1;
    check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.char_ready}, 32'd0);
    tick();
    check("mid_after_wr_en", {31'd0, wr_en}, 32'd0);
    check("mid_col", {25'd0, cursor_col}, 32'd0);
    check("mid_row", {26'd0, cursor_row}, 32'd0);
    check("mid_scroll", {26'd0, scroll_row}, 32'd0);
    reset = 1'b0;
    check_clear_screen("reclear", 3'd7, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Writer side of the 80x60 text-mode video path.
- Accepts a byte stream with a valid/ready handshake and interprets control codes.
- Maintains the cursor and writes character and colour cells into the dual-port character RAM that the VGA text renderer reads.
- Implements hardware scrolling through a circular row offset (scroll_row), so no read-back or copy is needed.

Parameters:
COLS, 80, columns per line; cursor_col range 0..COLS-1.
ROWS, 60, lines per screen; physical and logical rows range 0..ROWS-1.
CLEAR_ON_RESET, 1, when 1, the block clears the whole screen after reset.

Ports:
clk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous reset, active-high.
char_in  in  8  byte to display or control code.
fg_in  in  3  foreground colour, sampled with each accepted byte.
bg_in  in  3  background colour, sampled with each accepted byte.
char_valid  in  1  char_in, fg_in and bg_in are valid.
char_ready  out  1  block can accept a byte this cycle.
wr_en  out  1  character RAM write strobe, one cycle per cell.
wr_addr  out  13  {col[6:0], physical_row[5:0]}, matching the renderer's characterPos layout.
wr_char  out  8  character code to write.
wr_fg  out  3  foreground colour to write.
wr_bg  out  3  background colour to write.
cursor_col  out  7  logical cursor column.
cursor_row  out  6  logical cursor row; 0 is the top visible line.
scroll_row  out  6  physical RAM row shown as the top line. The renderer adds this value modulo ROWS.
busy  out  1  clear or scroll sequence in progress.

Behaviour:
- Physical row = (scroll_row + cursor_row) mod ROWS. All arithmetic wraps at ROWS, never at 64.
- Handshake:
  - A byte is accepted on a posedge where char_valid && char_ready.
  - char_ready = (state == IDLE) && !reset.
  - Any resulting write appears as registered outputs on the following cycle (latency 1).
  - On accept, fg_in and bg_in latch into the attribute register attr.
- State machine:
  - IDLE: decode the accepted byte.
    - 0x20..0x7F: write {char_in, attr} at the cursor, then col+1. At col==COLS-1: col=0, then perform a line advance.
    - 0x0D (CR): col=0; no write.
    - 0x0A (LF): line advance; col is unchanged.
    - 0x08 (BS): if col>0, col-1 and write 0x20 at the new position. At col 0: no effect, no write.
    - 0x0C (FF): col=0, row=0, scroll_row=0, go to CLR_SCREEN.
    - All other codes are consumed with no effect.
  - Line advance:
    - If cursor_row<ROWS-1: row+1, stay in IDLE.
    - Else: go to CLR_LINE targeting physical row = scroll_row; cursor_row stays ROWS-1.
  - CLR_LINE: write 0x20/attr at cols 0..COLS-1 of the target row, one per cycle (80 writes). On the last write, scroll_row = (scroll_row+1) mod ROWS, then go to IDLE.
  - CLR_SCREEN: write 0x20/attr over all COLS*ROWS cells (4800 writes), rows in the outer loop and cols in the inner loop, physical row order 0..59. Then go to IDLE.
  - busy = 1 in CLR_LINE and CLR_SCREEN; char_ready = 0 there.
- Printable at col COLS-1 on row ROWS-1: cell written in cycle N+1, CLR_LINE begins in cycle N+2, and the cursor lands at (0, ROWS-1).
- Reset values:
  - wr_en=0, wr_addr=0, wr_char=0x20, wr_fg=3'b111, wr_bg=3'b000, attr=(7,0).
  - cursor (0,0), scroll_row=0.
  - state = CLR_SCREEN if CLEAR_ON_RESET, else IDLE.
  - busy and char_ready follow the state.
- Reset asserted mid-sequence aborts it immediately; no further wr_en pulses occur until the post-reset clear starts.
- When wr_en is 0, wr_addr, wr_char, wr_fg and wr_bg are don't-care. The bench checks them only when wr_en=1.

Test Plan:
- Reset with CLEAR_ON_RESET=1:
  - exactly 4800 wr_en pulses, all wr_char=0x20, fg=7, bg=0;
  - first wr_addr=0, last wr_addr={7'd79,6'd59};
  - char_ready rises the cycle after the last write.
- Send 'A' (0x41) with fg=2, bg=1 at (0,0):
  - one cycle after accept: wr_en=1, wr_addr=0, wr_char=0x41, wr_fg=2, wr_bg=1;
  - cursor_col=1.
- Send 79 printables, then 'Z': 'Z' written at {79,0}; cursor becomes (0,1). Then CR, LF, LF gives cursor (0,3) with no writes.
- Cursor at (5,59), scroll_row=0, send LF:
  - 80 writes to physical row 0 with cols 0..79 and char 0x20;
  - busy high for 80 cycles, then scroll_row=1, cursor (5,59).
  - A following 'B' writes wr_addr={7'd5,6'd0}.
- Cursor at (0,4), send BS: no write, cursor unchanged. At (3,4), BS writes 0x20 at col 2 and cursor_col=2.
- Assert reset during the 2000th CLR_SCREEN write:
  - wr_en is 0 in the reset cycle;
  - cursor (0,0), scroll_row=0;
  - a fresh 4800-write clear follows.
